// File: rtl/feeder_pkg.sv
// Shared opcodes, state encoding and open-time scaling for the feeder sequencer.
// Imported by feeder_tick_gen and feeder_sequencer.
package feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_OPEN   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] OP_FEED     = 4'h1;
    localparam logic [3:0] OP_SET_OPEN = 4'h2;
    localparam logic [3:0] OP_ABORT    = 4'h3;

    localparam int OPEN_SCALE = 16;

    function automatic logic [7:0] scale_open(input logic [3:0] k);
        return 8'(32'(k) * OPEN_SCALE);
    endfunction

endpackage

// File: rtl/feeder_tick_gen.sv
// Timer prescaler: one-cycle tick every TICK_DIV enabled cycles.
// A synchronous restart realigns the tick to the start of a new phase.
import feeder_pkg::*;

module feeder_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/feeder_sequencer.sv
// Cat-feeder dispense sequencer: FEED / SET_OPEN / ABORT command FSM.
// Optional feature: define FEEDER_TOTAL_EN to enable the total_fed counter.
import feeder_pkg::*;

module feeder_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int OPEN_MS  = 200,
    parameter int GAP_MS   = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        servo_open,
    output logic        busy,
    output logic [3:0]  portions_left,
    output logic        done,
    output logic        err,
    output logic [15:0] total_fed
);

    localparam logic [7:0] OPEN_INIT = 8'(OPEN_MS);
    localparam logic [7:0] GAP_LEN   = 8'(GAP_MS);

    state_t      r_state;
    state_t      w_state_n;
    logic [3:0]  r_portions;
    logic [3:0]  w_portions_n;
    logic [7:0]  r_open_ms;
    logic [7:0]  w_open_ms_n;
    logic [7:0]  r_ticks;
    logic [7:0]  r_phase_len;
    logic        r_err;
    logic        w_err_n;
    logic        w_restart;
    logic        w_tick;
    logic        w_phase_en;
    logic        w_phase_end;
    logic        w_acc;
    logic        w_abort;
    logic [3:0]  w_op;
    logic [3:0]  w_arg;

    assign w_op    = cmd_data[7:4];
    assign w_arg   = cmd_data[3:0];
    assign w_acc   = cmd_valid && cmd_ready;
    assign w_abort = w_acc && (w_op == OP_ABORT);

    assign w_phase_en  = (r_state == ST_OPEN) || (r_state == ST_GAP);
    assign w_phase_end = w_tick && (r_ticks == r_phase_len - 8'd1);

    feeder_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_restart (w_restart),
        .i_en      (w_phase_en),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_n    = r_state;
        w_portions_n = r_portions;
        w_open_ms_n  = r_open_ms;
        w_err_n      = 1'b0;
        w_restart    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_op == OP_FEED && w_arg != 4'd0) begin
                        w_state_n    = ST_DECODE;
                        w_portions_n = w_arg;
                    end else if (w_op == OP_SET_OPEN && w_arg != 4'd0) begin
                        w_open_ms_n = scale_open(w_arg);
                    end else if (w_op != OP_ABORT) begin
                        w_err_n = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                w_state_n = ST_OPEN;
                w_restart = 1'b1;
            end
            ST_OPEN: begin
                if (w_abort) begin
                    w_state_n    = ST_IDLE;
                    w_portions_n = 4'd0;
                end else begin
                    w_err_n = w_acc;
                    if (w_phase_end) begin
                        w_portions_n = r_portions - 4'd1;
                        if (r_portions == 4'd1) begin
                            w_state_n = ST_DONE;
                        end else begin
                            w_state_n = ST_GAP;
                            w_restart = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (w_abort) begin
                    w_state_n    = ST_IDLE;
                    w_portions_n = 4'd0;
                end else begin
                    w_err_n = w_acc;
                    if (w_phase_end) begin
                        w_state_n = ST_OPEN;
                        w_restart = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_n    = ST_IDLE;
                w_portions_n = 4'd0;
                w_err_n      = w_acc && !w_abort;
            end
            default: begin
                w_state_n    = ST_IDLE;
                w_portions_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_portions <= 4'd0;
            r_open_ms  <= OPEN_INIT;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_portions <= w_portions_n;
            r_open_ms  <= w_open_ms_n;
            r_err      <= w_err_n;
        end
    end

    // open_ms is latched on every OPEN entry; GAP always uses the fixed length
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ticks     <= 8'd0;
            r_phase_len <= 8'd0;
        end else if (w_restart) begin
            r_ticks     <= 8'd0;
            r_phase_len <= (w_state_n == ST_OPEN) ? r_open_ms : GAP_LEN;
        end else if (w_tick) begin
            r_ticks <= r_ticks + 8'd1;
        end
    end

`ifdef FEEDER_TOTAL_EN
    logic [15:0] r_total;
    logic        w_count;

    assign w_count = (r_state == ST_OPEN) && w_phase_end && !w_abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_total <= 16'd0;
        end else if (w_count && r_total != 16'hFFFF) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign total_fed = r_total;
`else
    assign total_fed = 16'd0;
`endif

    assign cmd_ready     = !reset && (r_state != ST_DECODE);
    assign servo_open    = (r_state == ST_OPEN);
    assign busy          = (r_state != ST_IDLE);
    assign portions_left = r_portions;
    assign done          = (r_state == ST_DONE) && !w_abort;
    assign err           = r_err;

endmodule

// File: tb/tb_feeder_sequencer.sv
// Self-checking bench: directed scenarios plus random commands,
// compared every cycle against a timeline-based reference model.
module tb_feeder_sequencer;

    localparam int TD = 4;
    localparam int OM = 3;
    localparam int GM = 2;
`ifdef FEEDER_TOTAL_EN
    localparam int TOT_EXP = 3;
`else
    localparam int TOT_EXP = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        servo_open;
    logic        busy;
    logic [3:0]  portions_left;
    logic        done;
    logic        err;
    logic [15:0] total_fed;

    feeder_sequencer #(
        .TICK_DIV (TD),
        .OPEN_MS  (OM),
        .GAP_MS   (GM)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .servo_open    (servo_open),
        .busy          (busy),
        .portions_left (portions_left),
        .done          (done),
        .err           (err),
        .total_fed     (total_fed)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // reference model: a feed is a timeline starting at its acceptance cycle
    bit m_act;
    bit m_err_pend;
    int m_t0, m_n, m_olen, m_open_ms, m_total, m_cyc;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act      = 0;
        m_err_pend = 0;
        m_open_ms  = OM;
        m_total    = 0;
    endtask

    task automatic cyc(input bit v, input logic [7:0] b);
        int d, e, p, l, k, r, pl, op, arg;
        bit srv, bsy, dn, rdy, at_done, last_open, acc, ab;
        cmd_valid = v;
        cmd_data  = b;
        op  = int'(b[7:4]);
        arg = int'(b[3:0]);
        srv = 0; bsy = 0; dn = 0; rdy = 1; pl = 0;
        at_done = 0; last_open = 0;
        ab = v && (op == 3);
        if (m_act) begin
            d = m_cyc - m_t0;
            bsy = 1;
            if (d == 1) begin
                pl  = m_n;
                rdy = 0;
            end else begin
                e = d - 2;
                p = m_olen + GM * TD;
                l = m_n * m_olen + (m_n - 1) * GM * TD;
                if (e == l) begin
                    at_done = 1;
                    dn = !ab;
                end else begin
                    k = e / p;
                    r = e % p;
                    srv = (r < m_olen);
                    pl = (r < m_olen) ? m_n - k : m_n - k - 1;
                    last_open = (r == m_olen - 1);
                end
            end
        end
        acc = v && rdy;
        @(negedge clock);
        check("ready", int'(cmd_ready), int'(rdy));
        check("servo", int'(servo_open), int'(srv));
        check("busy", int'(busy), int'(bsy));
        check("portions", int'(portions_left), pl);
        check("done", int'(done), int'(dn));
        check("err", int'(err), int'(m_err_pend));
`ifdef FEEDER_TOTAL_EN
        check("total", int'(total_fed), m_total);
`else
        check("total", int'(total_fed), 0);
`endif
        @(posedge clock);
        m_err_pend = 0;
        if (m_act && last_open && !(acc && ab)) m_total++;
        if (m_act && at_done) m_act = 0;
        if (acc) begin
            if (!m_act && !at_done) begin
                if (op == 1 && arg != 0) begin
                    m_act  = 1;
                    m_t0   = m_cyc;
                    m_n    = arg;
                    m_olen = m_open_ms * TD;
                end else if (op == 2 && arg != 0) begin
                    m_open_ms = arg * 16;
                end else if (op != 3) begin
                    m_err_pend = 1;
                end
            end else if (ab) begin
                m_act = 0;
            end else begin
                m_err_pend = 1;
            end
        end
        m_cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic reset_dut();
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_servo", int'(servo_open), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_portions", int'(portions_left), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_total", int'(total_fed), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] b;
        int sel;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        m_cyc     = 0;
        model_reset();
        @(posedge clock);
        #1;
        reset_dut();
        idle(2);
        cyc(1'b1, 8'h12);
        idle(40);
        cyc(1'b1, 8'h10);
        idle(3);
        cyc(1'b1, 8'h70);
        idle(3);
        cyc(1'b1, 8'h21);
        idle(2);
        cyc(1'b1, 8'h11);
        idle(10);
        cyc(1'b1, 8'h21);
        idle(70);
        cyc(1'b1, 8'h13);
        idle(20);
        cyc(1'b1, 8'h30);
        idle(3);
        cyc(1'b1, 8'h12);
        idle(70);
        reset_dut();
        cyc(1'b1, 8'h11);
        idle(18);
        reset_dut();
        cyc(1'b1, 8'h12);
        idle(36);
        cyc(1'b1, 8'h13);
        idle(16);
        cyc(1'b1, 8'h30);
        idle(2);
        check("total_scn", int'(total_fed), TOT_EXP);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel <= 4) b = {4'h1, 4'($urandom_range(0, 4))};
                else if (sel == 5) b = {4'h2, 4'($urandom_range(0, 1))};
                else if (sel <= 7) b = {4'h3, 4'($urandom)};
                else if (sel == 8) b = {4'($urandom_range(4, 15)), 4'($urandom)};
                else b = {4'h0, 4'($urandom)};
                cyc(1'b1, b);
            end else begin
                cyc(1'b0, 8'($urandom));
            end
        end
        idle(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
